// File: rtl/dmem_mmio.sv
// Data/stack memory with byte-lane stores and a buffered UART RX window.
// Optional DMEM_FAULT_LATCH_EN adds a fault-address register at UART_STAT_ADDR+4.
module dmem_mmio #(
  parameter logic [31:0] DATA_BASE      = 32'h0000_1000,
  parameter int          DATA_WORDS     = 100,
  parameter logic [31:0] STACK_TOP      = 32'hFFFF_FFFC,
  parameter int          STACK_WORDS    = 10,
  parameter logic [31:0] UART_DATA_ADDR = 32'h0000_1200,
  parameter logic [31:0] UART_STAT_ADDR = 32'h0000_1204,
  parameter int          FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Size,
  input  logic [31:0] A,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        fault,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int DIDX_W = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam int SIDX_W = (STACK_WORDS > 1) ? $clog2(STACK_WORDS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [29:0] DATA_LO  = DATA_BASE[31:2];
  localparam logic [29:0] DATA_HI  = DATA_LO + 30'(DATA_WORDS - 1);
  localparam logic [29:0] STACK_HI = STACK_TOP[31:2];
  localparam logic [29:0] STACK_LO = STACK_HI - 30'(STACK_WORDS - 1);
  localparam logic [29:0] UDATA_WA = UART_DATA_ADDR[31:2];
  localparam logic [29:0] USTAT_WA = UART_STAT_ADDR[31:2];
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [29:0]       wa;
  logic              data_hit, stack_hit, udata_hit, ustat_hit, fa_hit;
  logic              misalign, mapped, word_op;
  logic [DIDX_W-1:0] data_idx;
  logic [SIDX_W-1:0] stack_idx;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic              mem_we;

  logic [31:0]       data_mem  [DATA_WORDS];
  logic [31:0]       stack_mem [STACK_WORDS];

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count;
  logic              ovf_q, full, not_empty, pop, push, ovf_set, ovf_clr;
  logic              fault_pend;
  logic [31:0]       status;

  assign wa        = A[31:2];
  assign data_hit  = (wa >= DATA_LO) && (wa <= DATA_HI);
  assign stack_hit = (wa >= STACK_LO) && (wa <= STACK_HI);
  assign udata_hit = (wa == UDATA_WA);
  assign ustat_hit = (wa == USTAT_WA);
  assign data_idx  = DIDX_W'(wa - DATA_LO);
  assign stack_idx = SIDX_W'(STACK_HI - wa);
  assign word_op   = (Size == 2'b10);

  assign misalign = (Size == 2'b11) || ((Size == 2'b01) && A[0]) ||
                    (word_op && (A[1:0] != 2'b00));
  assign mapped   = data_hit || stack_hit || udata_hit || ustat_hit || fa_hit;
  assign fault    = (MemRead || MemWrite) && (misalign || !mapped);
  assign mem_we   = MemWrite && !fault;

  // Store data is replicated across lanes; the enables pick which lanes land.
  always_comb begin
    be = 4'b0000;
    wd = WriteData;
    case (Size)
      2'b00: begin
        be[A[1:0]] = 1'b1;
        wd = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be = A[1] ? 4'b1100 : 4'b0011;
        wd = {2{WriteData[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DATA_WORDS; i++) data_mem[i] <= '0;
      for (int i = 0; i < STACK_WORDS; i++) stack_mem[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b] && data_hit) data_mem[data_idx][8*b +: 8] <= wd[8*b +: 8];
        else if (be[b] && stack_hit) stack_mem[stack_idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  assign full      = (count == DEPTH_C);
  assign not_empty = (count != '0);
  assign rx_ready  = !full;
  assign pop       = MemRead && udata_hit && !fault && not_empty;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push      = rx_valid && (!full || pop);
  assign ovf_set   = rx_valid && full && !pop;
  assign ovf_clr   = mem_we && ustat_hit && word_op && WriteData[2];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

`ifdef DMEM_FAULT_LATCH_EN
  logic [31:0] fault_addr_q;
  logic        fault_pend_q;

  assign fa_hit     = (wa == USTAT_WA + 30'd1);
  assign fault_pend = fault_pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_addr_q <= '0;
      fault_pend_q <= 1'b0;
    end else if (fault && !fault_pend_q) begin
      fault_addr_q <= A;
      fault_pend_q <= 1'b1;
    end else if (mem_we && fa_hit && word_op) begin
      fault_addr_q <= '0;
      fault_pend_q <= 1'b0;
    end
  end
`else
  assign fa_hit     = 1'b0;
  assign fault_pend = 1'b0;
`endif

  assign status = {16'h0000, 8'(count), 4'h0, fault_pend, ovf_q, full, not_empty};

  always_comb begin
    ReadData = 32'hFFFF_FFFF;
    if (data_hit)        ReadData = data_mem[data_idx];
    else if (stack_hit)  ReadData = stack_mem[stack_idx];
    else if (udata_hit)  ReadData = not_empty ? {24'h0, fifo_mem[rd_ptr]} : 32'hFFFF_FFFF;
    else if (ustat_hit)  ReadData = status;
`ifdef DMEM_FAULT_LATCH_EN
    else if (fa_hit)     ReadData = fault_addr_q;
`endif
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: directed test-plan sequences plus random traffic
// checked against a byte-array/queue reference model.
module tb_dmem_mmio;

  localparam int          NDATA  = 100;
  localparam int          NSTACK = 10;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] DBASE  = 32'h0000_1000;
  localparam logic [31:0] STOP   = 32'hFFFF_FFFC;
  localparam logic [31:0] UDATA  = 32'h0000_1200;
  localparam logic [31:0] USTAT  = 32'h0000_1204;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemWrite = 1'b0, MemRead = 1'b0;
  logic [1:0]  Size = 2'b10;
  logic [31:0] A = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic        fault;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  dmem_mmio dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .MemRead(MemRead), .Size(Size),
    .A(A), .WriteData(WriteData), .ReadData(ReadData), .fault(fault),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] q_rd[$];
  logic        q_flt[$];
  logic        q_rdy[$];
  string       q_name[$];

  // Reference model state
  logic [31:0] m_data[NDATA];
  logic [31:0] m_stack[NSTACK];
  logic [7:0]  m_fifo[$];
  logic        m_ovf;
  logic        m_pend;
  logic [31:0] m_fa;

  task automatic model_reset();
    for (int i = 0; i < NDATA; i++) m_data[i] = '0;
    for (int i = 0; i < NSTACK; i++) m_stack[i] = '0;
    m_fifo.delete();
    m_ovf = 1'b0;
    m_pend = 1'b0;
    m_fa = '0;
  endtask

  // region: 0 unmapped, 1 data, 2 stack, 3 uart data, 4 uart status, 5 fault addr
  task automatic model_step(input logic mr, input logic mw, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic rxv, input logic [7:0] rxd,
                            output logic [31:0] er, output logic ef, output logic ey);
    logic [31:0] aw, w;
    int region, idx, nb;
    logic bad, full;
    aw = a & 32'hFFFF_FFFC;
    region = 0;
    idx = 0;
    if (aw >= DBASE && aw <= DBASE + 32'(4 * (NDATA - 1))) begin
      region = 1; idx = int'((aw - DBASE) / 4);
    end else if (aw >= STOP - 32'(4 * (NSTACK - 1)) && aw <= STOP) begin
      region = 2; idx = int'((STOP - aw) / 4);
    end else if (aw == UDATA) region = 3;
    else if (aw == USTAT) region = 4;
`ifdef DMEM_FAULT_LATCH_EN
    else if (aw == USTAT + 32'd4) region = 5;
`endif
    bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    ef  = (mr || mw) && (bad || region == 0);
    full = (m_fifo.size() == DEPTH);
    ey  = !full;
    case (region)
      1: er = m_data[idx];
      2: er = m_stack[idx];
      3: er = (m_fifo.size() > 0) ? {24'h0, m_fifo[0]} : 32'hFFFF_FFFF;
      4: er = {16'h0, 8'(m_fifo.size()), 4'h0, m_pend, m_ovf, full, m_fifo.size() > 0};
      5: er = m_fa;
      default: er = 32'hFFFF_FFFF;
    endcase
    if (mw && !ef && (region == 1 || region == 2)) begin
      w = (region == 1) ? m_data[idx] : m_stack[idx];
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      for (int k = 0; k < nb; k++) w[8 * (int'(a[1:0]) + k) +: 8] = wd[8 * k +: 8];
      if (region == 1) m_data[idx] = w; else m_stack[idx] = w;
    end
    if (mr && region == 3 && !ef && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (mw && !ef && region == 4 && sz == 2'd2 && wd[2]) m_ovf = 1'b0;
    if (rxv) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(rxd);
      else m_ovf = 1'b1;
    end
`ifdef DMEM_FAULT_LATCH_EN
    if (ef && !m_pend) begin
      m_pend = 1'b1; m_fa = a;
    end else if (mw && !ef && region == 5 && sz == 2'd2) begin
      m_pend = 1'b0; m_fa = '0;
    end
`endif
  endtask

  task automatic acc(input string nm, input logic mr, input logic mw, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic rxv, input logic [7:0] rxd);
    logic [31:0] er;
    logic ef, ey;
    @(posedge clk); #1;
    MemRead = mr; MemWrite = mw; Size = sz; A = a; WriteData = wd;
    rx_valid = rxv; rx_data = rxd;
    model_step(mr, mw, sz, a, wd, rxv, rxd, er, ef, ey);
    if (mr || mw) begin
      q_rd.push_back(er); q_flt.push_back(ef); q_rdy.push_back(ey); q_name.push_back(nm);
    end
  endtask

  task automatic idle();
    acc("idle", 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 8'h0);
  endtask

  always @(negedge clk) begin
    if (!rst && (MemRead || MemWrite)) begin
      if (q_rd.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL scoreboard_underflow: access at A=%h with no expectation", A);
      end else begin
        logic [31:0] er; logic ef, ey; string nm;
        er = q_rd.pop_front(); ef = q_flt.pop_front(); ey = q_rdy.pop_front(); nm = q_name.pop_front();
        ntests += 3;
        if (ReadData !== er) begin
          nfail++; $display("FAIL %s ReadData: got %h expected %h (A=%h)", nm, ReadData, er, A);
        end
        if (fault !== ef) begin
          nfail++; $display("FAIL %s fault: got %b expected %b (A=%h)", nm, fault, ef, A);
        end
        if (rx_ready !== ey) begin
          nfail++; $display("FAIL %s rx_ready: got %b expected %b", nm, rx_ready, ey);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rand_addr();
    int c, off;
    off = $urandom_range(0, 3);
    c = $urandom_range(0, 9);
    case (c)
      0, 1, 2: return DBASE + 32'(4 * $urandom_range(0, NDATA - 1)) + 32'(off);
      3, 4:    return STOP - 32'(4 * $urandom_range(0, NSTACK - 1)) + 32'(off);
      5, 6:    return UDATA + ((off == 0) ? 32'd0 : 32'(off));
      7:       return USTAT + 32'(off & 1);
      8:       return USTAT + 32'd4;
      default: begin
        case ($urandom_range(0, 3))
          0: return DBASE - 32'd4;
          1: return DBASE + 32'(4 * NDATA);
          2: return STOP - 32'(4 * NSTACK);
          default: return $urandom;
        endcase
      end
    endcase
  endfunction

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    acc("rst_data0",   1, 0, 2'd2, 32'h0000_1000, 0, 0, 0);
    acc("rst_stack0",  1, 0, 2'd2, 32'hFFFF_FFFC, 0, 0, 0);
    acc("rst_status",  1, 0, 2'd2, USTAT, 0, 0, 0);
    acc("rst_rxempty", 1, 0, 2'd2, UDATA, 0, 0, 0);

    acc("st_word",     0, 1, 2'd2, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0);
    acc("st_byte",     0, 1, 2'd0, 32'h0000_1006, 32'h0000_0055, 0, 0);
    acc("ld_merged",   1, 0, 2'd2, 32'h0000_1004, 0, 0, 0);
    acc("st_half_mis", 0, 1, 2'd1, 32'h0000_1005, 32'h0000_AAAA, 0, 0);
    acc("ld_unchg",    1, 0, 2'd2, 32'h0000_1004, 0, 0, 0);
    acc("st_half_hi",  0, 1, 2'd1, 32'h0000_1006, 32'h0000_1234, 0, 0);
    acc("ld_half_hi",  1, 0, 2'd2, 32'h0000_1004, 0, 0, 0);
    acc("ld_size11",   1, 0, 2'd3, 32'h0000_1000, 0, 0, 0);
    acc("ld_data_end", 1, 0, 2'd2, DBASE + 32'(4 * (NDATA - 1)), 0, 0, 0);
    acc("ld_data_past",1, 0, 2'd2, DBASE + 32'(4 * NDATA), 0, 0, 0);

    acc("st_stack9",   0, 1, 2'd2, 32'hFFFF_FFD8, 32'h1234_5678, 0, 0);
    acc("ld_stack9",   1, 0, 2'd2, 32'hFFFF_FFD8, 0, 0, 0);
    acc("st_stack10",  0, 1, 2'd2, 32'hFFFF_FFD4, 32'h1111_1111, 0, 0);

    acc("push41", 0, 0, 2'd2, 0, 0, 1, 8'h41);
    acc("push42", 0, 0, 2'd2, 0, 0, 1, 8'h42);
    acc("push43", 0, 0, 2'd2, 0, 0, 1, 8'h43);
    acc("stat3",  1, 0, 2'd2, USTAT, 0, 0, 0);
    acc("stat_again", 1, 0, 2'd2, USTAT, 0, 0, 0);
    acc("pop41",  1, 0, 2'd2, UDATA, 0, 0, 0);
    acc("pop42",  1, 0, 2'd2, UDATA, 0, 0, 0);
    acc("pop43",  1, 0, 2'd2, UDATA, 0, 0, 0);
    acc("pop_empty", 1, 0, 2'd2, UDATA, 0, 0, 0);
    acc("stat0",  1, 0, 2'd2, USTAT, 0, 0, 0);

    for (int i = 0; i < 9; i++) acc("push_fill", 0, 0, 2'd2, 0, 0, 1, 8'(8'h60 + i));
    acc("stat_full_ovf", 1, 0, 2'd2, USTAT, 0, 0, 0);
    acc("pushpop_full",  1, 0, 2'd2, UDATA, 0, 1, 8'h7A);
    acc("stat_after_pp", 1, 0, 2'd2, USTAT, 0, 0, 0);
    acc("st_byte_stat",  0, 1, 2'd0, USTAT, 32'h0000_00FF, 0, 0);
    acc("stat_keep_ovf", 1, 0, 2'd2, USTAT, 0, 0, 0);
    acc("clr_ovf",       0, 1, 2'd2, USTAT, 32'h0000_0004, 0, 0);
    acc("stat_cleared",  1, 0, 2'd2, USTAT, 0, 0, 0);
    acc("st_udata",      0, 1, 2'd2, UDATA, 32'h0000_00AB, 0, 0);
    for (int i = 0; i < 9; i++) acc("drain", 1, 0, 2'd2, UDATA, 0, 0, 0);
    acc("fa_addr", 1, 0, 2'd2, USTAT + 32'd4, 0, 0, 0);
    acc("fa_clear", 0, 1, 2'd2, USTAT + 32'd4, 32'h5, 0, 0);
    acc("fa_after", 1, 0, 2'd2, USTAT + 32'd4, 0, 0, 0);
    acc("stat_end_dir", 1, 0, 2'd2, USTAT, 0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      int op;
      logic [1:0] sz;
      op = $urandom_range(0, 9);
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      acc("random", op < 5, (op >= 5 && op < 8), sz, rand_addr(), $urandom,
          $urandom_range(0, 9) < 4, 8'($urandom));
    end

    acc("pre_rst_store", 0, 1, 2'd2, 32'h0000_1008, 32'hCAFE_F00D, 0, 0);
    for (int i = 0; i < 5; i++) acc("pre_rst_push", 0, 0, 2'd2, 0, 0, 1, 8'(8'h30 + i));
    acc("pre_rst_stat", 1, 0, 2'd2, USTAT, 0, 0, 0);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b1; Size = 2'd2; A = 32'h0000_1008; WriteData = 32'h5A5A_5A5A;
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    MemWrite = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    acc("post_rst_word",  1, 0, 2'd2, 32'h0000_1008, 0, 0, 0);
    acc("post_rst_stat",  1, 0, 2'd2, USTAT, 0, 0, 0);
    acc("post_rst_rx",    1, 0, 2'd2, UDATA, 0, 0, 0);
    acc("post_rst_word2", 1, 0, 2'd2, 32'h0000_1004, 0, 0, 0);
    idle();
    idle();

    ntests++;
    if (q_rd.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_leftover: %0d expectations never matched, required 0", q_rd.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
